// File: rtl/p2s_pkg.sv
// p2s_pkg: shared state encoding and defaults for the parallel-to-serial shifter
package p2s_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_PAR   = 2'b10
  } p2s_state_t;
  localparam logic IDLE_BIT_DEFAULT = 1'b1;
endpackage

// File: rtl/p2s_shifter_if.sv
// p2s_shifter_if: word handshake in, serial bit stream out
interface p2s_shifter_if #(parameter int W = 8);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         x;
  logic         sof;
  logic         busy;
  modport master (output din, din_valid, input din_ready, x, sof, busy);
  modport slave  (input din, din_valid, output din_ready, x, sof, busy);
endinterface

// File: rtl/p2s_bitcnt.sv
// p2s_bitcnt: frame-position counter; tc marks the final frame cycle (P2S_PARITY_EN adds one)
module p2s_bitcnt #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic ld
);
  localparam int CW = $clog2(W + 1);
`ifdef P2S_PARITY_EN
  localparam int LAST = W;
`else
  localparam int LAST = W - 1;
`endif
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!reset || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign tc = cnt == CW'(LAST);
  assign ld = cnt == CW'(W - 1);
endmodule

// File: rtl/p2s_shifter.sv
// p2s_shifter: W-bit words out MSB first on x; P2S_PARITY_EN appends an even-parity bit
module p2s_shifter
  import p2s_pkg::*;
#(
  parameter int   W        = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  p2s_shifter_if.slave  bus
);
  p2s_state_t state, state_n;
  logic [W-2:0] sr;
  logic x_q, sof_q, busy_q, ready, take, last, tc, ld;
`ifdef P2S_PARITY_EN
  logic par;
`endif
  p2s_bitcnt #(.W(W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (take),
    .en   (state_n != ST_IDLE && !take),
    .tc   (tc),
    .ld   (ld)
  );
  always_comb begin
    ready = reset && (state == ST_IDLE || tc);
    take  = ready && bus.din_valid;
    last  = state == ST_SHIFT && ld;
`ifdef P2S_PARITY_EN
    state_n = take ? ST_SHIFT : last ? ST_PAR : state == ST_PAR ? ST_IDLE : state;
`else
    state_n = take ? ST_SHIFT : last ? ST_IDLE : state;
`endif
  end
  always_ff @(posedge clk)
    state <= reset ? state_n : ST_IDLE;
  // sr holds only the bits not yet on x; the MSB goes straight to x at load
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr     <= '0;
      x_q    <= IDLE_BIT;
      sof_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef P2S_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      sof_q <= take;
      if (take) begin
        sr     <= bus.din[W-2:0];
        x_q    <= bus.din[W-1];
        busy_q <= 1'b1;
`ifdef P2S_PARITY_EN
        par    <= ^bus.din;
`endif
      end else if (state_n == ST_SHIFT) begin
        sr  <= sr << 1;
        x_q <= sr[W-2];
`ifdef P2S_PARITY_EN
      end else if (state_n == ST_PAR) begin
        x_q <= par;
`endif
      end else begin
        x_q    <= IDLE_BIT;
        busy_q <= 1'b0;
      end
    end
  end
  assign bus.din_ready = ready;
  assign bus.x         = x_q;
  assign bus.sof       = sof_q;
  assign bus.busy      = busy_q;
endmodule
